pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB regs).
//  Detects load-use hazards, flushes on taken branch/jump, and holds the pipeline
//  while a multi-cycle data-memory access completes, with a timeout into a sticky error state.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles spent in WAIT without mem_ack before entering ERR (>=2)
//  CNT_W        5   width of wait counter; must satisfy 2**CNT_W > MEM_TIMEOUT
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous, active-low reset
//  id_rs1          in   5   rs1 of instruction in ID
//  id_rs2          in   5   rs2 of instruction in ID
//  id_rs1_used     in   1   ID instruction reads rs1
//  id_rs2_used     in   1   ID instruction reads rs2
//  ex_rd           in   5   destination reg of instruction in EX
//  ex_mem_read     in   1   EX instruction is a load
//  ex_branch_taken in   1   EX resolved a taken branch/jump (redirect)
//  mem_req         in   1   MEM stage holds a load/store
//  mem_ack         in   1   data memory completes access this cycle
//  stall_if        out  1   hold PC / IF/ID
//  stall_id        out  1   hold ID/EX input side (ID instruction)
//  stall_ex        out  1   hold EX/MEM
//  stall_mem       out  1   hold MEM stage contents
//  flush_id        out  1   clear IF/ID to NOP
//  flush_ex        out  1   load bubble into ID/EX
//  bubble_wb       out  1   force MEM/WB rf_we_i to 0 this cycle
//  state_o         out  2   FSM state: 00 RUN, 01 WAIT, 10 ERR
//  err_o           out  1   sticky memory timeout error
// BEHAVIOUR
//  - Reset (rst=0): state=RUN, wait_cnt=0, err_o=0; all control outputs forced 0 while rst=0.
//  - state and wait_cnt are registered; control outputs are combinational from state+inputs (0 latency).
//  - Load-use hit (LU): ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
//  RUN:
//  - mem_req & !mem_ack: stall_if=stall_id=stall_ex=stall_mem=1, bubble_wb=1, flush_*=0; next WAIT, wait_cnt<=1.
//  - mem_req & mem_ack (single-cycle access): no memory stall; evaluate below.
//  - else ex_branch_taken: flush_id=flush_ex=1, no stalls (branch wins over LU; ID instr is discarded).
//  - else LU: stall_if=stall_id=1, flush_ex=1; exactly one bubble per hazard (next cycle the load is in MEM).
//  - else all outputs 0.
//  WAIT:
//  - !mem_ack: all stalls=1, bubble_wb=1, flush_*=0 (pending branch/LU deferred; EX is frozen);
//    wait_cnt<=wait_cnt+1; if wait_cnt==MEM_TIMEOUT-1 next ERR.
//  - mem_ack: stall_mem=stall_ex=0 and outputs evaluated as in RUN excluding memory stall; next RUN, wait_cnt<=0.
//  - mem_ack on the timeout cycle: ack wins, go RUN.
//  - mem_req dropping in WAIT without ack is illegal; treated as ack.
//  ERR:
//  - err_o=1, all stalls=1, bubble_wb=1, flush_*=0; only reset exits.
//  - Reset mid-WAIT/ERR: immediate return to RUN, counters cleared.
// CONFIGURATION
//  PIPE_HAZARD_PERF_EN defined: adds outputs perf_lu_cnt[31:0] and perf_wait_cnt[31:0];
//    incremented on each LU-stall cycle / each cycle with stall_mem=1; saturate at 32'hFFFF_FFFF;
//    reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: rst=0 with all inputs=1 -> all outputs 0, state_o=00; release -> RUN.
//  2 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> stall_if=stall_id=flush_ex=1 for 1 cycle.
//    Same with ex_rd=0 -> no stall.
//  3 Branch+LU same cycle: ex_branch_taken=1 with LU hit -> flush_id=flush_ex=1, stall_if=0.
//  4 Mem wait: mem_req=1, ack at 4th cycle -> 3 cycles all stalls=1, bubble_wb=1, state_o=01;
//    ack cycle stalls=0; then RUN.
//  5 Timeout: mem_req=1, no ack, MEM_TIMEOUT=16 -> state_o=10 and err_o=1 after 16 cycles;
//    stays until rst=0.
//  6 PERF_EN build: two LU hazards + 3-cycle wait -> perf_lu_cnt=2, perf_wait_cnt=3.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use, branch flush, memory wait/timeout.
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ack,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       stall_mem,
    output logic       flush_id,
    output logic       flush_ex,
    output logic       bubble_wb,
    output logic [1:0] state_o,
    output logic       err_o
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic lu_hit;
    logic mem_miss;
    logic wait_last;
    logic hold_all;
    logic resolve;
    logic lu_stall;

    always_comb begin
        lu_hit = ex_mem_read && (ex_rd != '0) &&
                 ((id_rs1_used && (id_rs1 == ex_rd)) ||
                  (id_rs2_used && (id_rs2 == ex_rd)));
        // A request dropping while waiting is treated the same as an ack.
        mem_miss  = mem_req && !mem_ack;
        wait_last = (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        hold_all   = 1'b0;
        resolve    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_miss) begin
                    hold_all   = 1'b1;
                    state_d    = ST_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end else begin
                    resolve = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_miss) begin
                    hold_all = 1'b1;
                    if (wait_last) begin
                        state_d    = ST_ERR;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    resolve    = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_ERR: begin
                hold_all = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Outputs are held low for the whole time rst is asserted.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        bubble_wb = 1'b0;
        state_o   = 2'b00;
        err_o     = 1'b0;
        lu_stall  = 1'b0;
        if (rst) begin
            if (hold_all) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
                bubble_wb = 1'b1;
            end else if (resolve) begin
                if (ex_branch_taken) begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (lu_hit) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                    lu_stall = 1'b1;
                end
            end
            state_o = state_q;
            err_o   = (state_q == ST_ERR);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_lu_q, perf_lu_d;
    logic [31:0] perf_wait_q, perf_wait_d;

    always_comb begin
        perf_lu_d   = perf_lu_q;
        perf_wait_d = perf_wait_q;
        if (lu_stall && (perf_lu_q != '1)) begin
            perf_lu_d = perf_lu_q + 1'b1;
        end
        if (stall_mem && (perf_wait_q != '1)) begin
            perf_wait_d = perf_wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lu_q   <= '0;
            perf_wait_q <= '0;
        end else begin
            perf_lu_q   <= perf_lu_d;
            perf_wait_q <= perf_wait_d;
        end
    end

    always_comb begin
        perf_lu_cnt   = perf_lu_q;
        perf_wait_cnt = perf_wait_q;
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by randomized traffic
// compared against a behavioural model based on consecutive unacknowledged memory cycles.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, mem_req, mem_ack;
    logic       stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb, err_o;
    logic [1:0] state_o;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_lu_cnt, perf_wait_cnt;
`endif

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .bubble_wb(bubble_wb),
        .state_o(state_o), .err_o(err_o)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_lu_cnt(perf_lu_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Model state: number of consecutive unacknowledged memory cycles, sticky error, perf totals.
    int          m_misses = 0;
    bit          m_err    = 1'b0;
    int unsigned m_lu     = 0;
    int unsigned m_wait   = 0;
    bit          e_lu_stall;
    bit          e_stall_mem;
    bit          e_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_now();
        logic [6:0] e_ctl;
        logic [1:0] e_st;
        logic       e_er;
        bit         lu;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        e_ctl = 7'b0; e_st = 2'd0; e_er = 1'b0;
        e_lu_stall = 1'b0; e_hold = 1'b0;
        if (rst) begin
            if (m_err) begin
                e_ctl = 7'b1111001; e_st = 2'd2; e_er = 1'b1;
            end else begin
                e_st   = (m_misses > 0) ? 2'd1 : 2'd0;
                e_hold = mem_req && !mem_ack;
                if (e_hold)               e_ctl = 7'b1111001;
                else if (ex_branch_taken) e_ctl = 7'b0000110;
                else if (lu) begin
                    e_ctl = 7'b1100010;
                    e_lu_stall = 1'b1;
                end
            end
        end
        e_stall_mem = e_ctl[3];
        chk("ctl", {25'd0, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb},
            {25'd0, e_ctl});
        chk("state", {30'd0, state_o}, {30'd0, e_st});
        chk("err", {31'd0, err_o}, {31'd0, e_er});
`ifdef PIPE_HAZARD_PERF_EN
        chk("perf_lu", perf_lu_cnt, rst ? m_lu : 32'd0);
        chk("perf_wait", perf_wait_cnt, rst ? m_wait : 32'd0);
`endif
    endtask

    task automatic model_update();
        if (!rst) begin
            m_misses = 0; m_err = 1'b0; m_lu = 0; m_wait = 0;
        end else begin
            if (e_lu_stall)  m_lu++;
            if (e_stall_mem) m_wait++;
            if (!m_err) begin
                if (e_hold) begin
                    m_misses++;
                    if (m_misses == MEM_TIMEOUT) begin
                        m_err = 1'b1;
                        m_misses = 0;
                    end
                end else begin
                    m_misses = 0;
                end
            end
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_now();
            @(posedge clk);
            model_update();
            #1;
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr, input logic bt,
                         input logic req, input logic ack);
        id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        ex_rd = rd; ex_mem_read = mr; ex_branch_taken = bt; mem_req = req; mem_ack = ack;
    endtask

    initial begin
        int ack_thr;
        // Reset with every input high: outputs must all be low.
        rst = 1'b0;
        drive(5'h1f, 5'h1f, 1, 1, 5'h1f, 1, 1, 1, 1);
        cyc(2);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1);

        // Load-use on rs1, then rs2, then the x0 case that must not stall.
        drive(5, 0, 1, 0, 5, 1, 0, 0, 0);  cyc(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc(1);
        drive(3, 7, 1, 1, 7, 1, 0, 0, 0);  cyc(1);
        drive(5, 0, 1, 0, 5, 0, 0, 0, 0);  cyc(1);
        drive(0, 0, 1, 1, 0, 1, 0, 0, 0);  cyc(1);
        drive(9, 9, 0, 0, 9, 1, 0, 0, 0);  cyc(1);

        // Branch and load-use together: branch flush wins.
        drive(5, 0, 1, 0, 5, 1, 1, 0, 0);  cyc(1);
        // Single-cycle memory access with a load-use: no memory stall.
        drive(5, 0, 1, 0, 5, 1, 0, 1, 1);  cyc(1);

        // Memory wait: ack on the fourth cycle, then idle.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  cyc(3);
        drive(5, 0, 1, 0, 5, 1, 0, 1, 1);  cyc(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc(1);

        // Request dropped mid-wait is treated as an ack.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  cyc(2);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);  cyc(1);

        // Ack on the last cycle before timeout still returns to RUN.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  cyc(MEM_TIMEOUT - 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);  cyc(1);

        // Timeout into the sticky error state; acks and branches do not leave it.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  cyc(MEM_TIMEOUT);
        drive(5, 0, 1, 0, 5, 1, 1, 1, 1);  cyc(3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc(1);
        rst = 1'b0;                        cyc(1);
        rst = 1'b1;                        cyc(1);

        // Reset asserted in the middle of a wait.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  cyc(4);
        rst = 1'b0;                        cyc(1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc(1);

        // Randomized traffic with varying ack likelihood and occasional resets.
        for (int blk = 0; blk < 8; blk++) begin
            ack_thr = (blk % 4 == 3) ? 0 : int'($urandom_range(2, 7));
            for (int i = 0; i < 100; i++) begin
                rst             = ($urandom_range(0, 63) != 0);
                id_rs1          = 5'($urandom_range(0, 3));
                id_rs2          = 5'($urandom_range(0, 3));
                id_rs1_used     = 1'($urandom_range(0, 1));
                id_rs2_used     = 1'($urandom_range(0, 1));
                ex_rd           = 5'($urandom_range(0, 3));
                ex_mem_read     = 1'($urandom_range(0, 1));
                ex_branch_taken = ($urandom_range(0, 5) == 0);
                mem_req         = ($urandom_range(0, 2) != 0);
                mem_ack         = (int'($urandom_range(0, 7)) < ack_thr);
                cyc(1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
